// File: rtl/uart_baud_tick.sv
// Bit-period divider for the UART pair: counts CLOCK_DIV-1 down to 0 and pulses tick
// on the cycle the count is 0, reloading on that edge or whenever restart is high.
module uart_baud_tick #(
  parameter int CLOCK_DIV = 104
) (
  input  logic clock,
  input  logic resetn,
  input  logic restart,
  output logic tick
);

  localparam int DW = $clog2(CLOCK_DIV);
  localparam logic [DW-1:0] RELOAD = DW'(CLOCK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div <= '0;
    end else if (restart || (div == '0)) begin
      div <= RELOAD;
    end else begin
      div <= div - 1'b1;
    end
  end

  assign tick = (div == '0);

  a_div_range: assert property (@(posedge clock) disable iff (!resetn) div <= RELOAD);

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-stream byte sink driving an 8N1-style serial line (start, data LSB-first, stop).
// Define AXIS_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module axis_uart_tx #(
  parameter int CLOCK_DIV = 104,
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [DATA_BITS-1:0] idata,
  input  logic                 ivalid,
  output logic                 iready,
  output logic                 txd,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);

`ifdef AXIS_UART_TX_PARITY_EN
  localparam int SW = 3;
  localparam logic [SW-1:0] S_PARITY = 3'd4;
`else
  localparam int SW = 2;
`endif
  localparam logic [SW-1:0] S_IDLE  = SW'(0);
  localparam logic [SW-1:0] S_START = SW'(1);
  localparam logic [SW-1:0] S_DATA  = SW'(2);
  localparam logic [SW-1:0] S_STOP  = SW'(3);

  logic [SW-1:0]        state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic                 txd_n, busy_n, iready_n;
  logic                 accept, tick;

  assign accept = ivalid && iready;

  // The divider restarts on accept so the start bit is a full CLOCK_DIV cycles.
  uart_baud_tick #(.CLOCK_DIV(CLOCK_DIV)) u_baud (
    .clock   (clock),
    .resetn  (resetn),
    .restart (accept),
    .tick    (tick)
  );

`ifdef AXIS_UART_TX_PARITY_EN
  logic parity, parity_n;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) parity <= 1'b0;
    else         parity <= parity_n;
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      iready  <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      txd     <= txd_n;
      busy    <= busy_n;
      iready  <= iready_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    txd_n     = txd;
    busy_n    = busy;
    iready_n  = iready;
`ifdef AXIS_UART_TX_PARITY_EN
    parity_n  = parity;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n  = S_START;
          shift_n  = idata;
          txd_n    = 1'b0;
          busy_n   = 1'b1;
          iready_n = 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
          parity_n = ^idata;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          state_n   = S_DATA;
          txd_n     = shift[0];
          bit_cnt_n = BW'(DATA_BITS - 1);
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt != '0) begin
            shift_n   = shift >> 1;
            txd_n     = shift[1];
            bit_cnt_n = bit_cnt - 1'b1;
          end else begin
`ifdef AXIS_UART_TX_PARITY_EN
            state_n = S_PARITY;
            txd_n   = parity;
`else
            state_n = S_STOP;
            txd_n   = 1'b1;
`endif
          end
        end
      end
`ifdef AXIS_UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_n = S_STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          state_n  = S_IDLE;
          busy_n   = 1'b0;
          iready_n = 1'b1;
        end
      end
      default: begin
        state_n  = S_IDLE;
        txd_n    = 1'b1;
        busy_n   = 1'b0;
        iready_n = 1'b1;
      end
    endcase
  end

  a_ready_idle: assert property (@(posedge clock) disable iff (!resetn) iready == (state == S_IDLE));
  a_idle_line:  assert property (@(posedge clock) disable iff (!resetn) !busy |-> txd);

endmodule

// File: tb/tb_axis_uart_tx.sv
// Randomized scoreboard bench for axis_uart_tx: a serial-line monitor rebuilds each frame
// from the expected word and checks every bit cycle, the decoded word and end-of-frame flags.
module tb_axis_uart_tx;

  localparam int CD = 4;
  localparam int DB = 8;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif
  localparam int FRAME = NBITS * CD;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic [DB-1:0] idata = '0;
  logic          ivalid = 1'b0;
  logic          iready, txd, busy;

  axis_uart_tx #(.CLOCK_DIV(CD), .DATA_BITS(DB)) dut (
    .clock  (clock),
    .resetn (resetn),
    .idata  (idata),
    .ivalid (ivalid),
    .iready (iready),
    .txd    (txd),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  int            n_assert = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            last_acc = 0;
  logic [DB-1:0] sb[$];
  int            fall_times[$];
  logic          in_frame = 1'b0;
  logic          post = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line level during bit slot idx of a frame carrying w.
  function automatic logic exp_bit(input logic [DB-1:0] w, input int idx);
    logic fr[$];
    fr.push_back(1'b0);
    for (int i = 0; i < DB; i++) fr.push_back(w[i]);
`ifdef AXIS_UART_TX_PARITY_EN
    fr.push_back(^w);
`endif
    fr.push_back(1'b1);
    return fr[idx];
  endfunction

  initial begin : mon
    logic          prev;
    int            fc;
    int            berr;
    logic [DB-1:0] ew;
    logic [DB-1:0] dec;
    prev = 1'b1;
    fc = 0;
    berr = 0;
    ew = '0;
    dec = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        in_frame = 1'b0;
        post = 1'b0;
      end else begin
        if (post) begin
          check("end_busy", busy, 0);
          check("end_iready", iready, 1);
          check("end_txd", txd, 1);
          post = 1'b0;
        end
        if (!in_frame && prev && !txd) begin
          fall_times.push_back(cyc);
          if (sb.size() == 0) begin
            check("unexpected_frame", sb.size(), 1);
            ew = '0;
          end else begin
            ew = sb.pop_front();
          end
          in_frame = 1'b1;
          fc = 0;
          berr = 0;
          dec = '0;
        end
        if (in_frame) begin
          if (txd !== exp_bit(ew, fc / CD) || busy !== 1'b1) berr++;
          if (fc % CD == CD / 2 && fc / CD >= 1 && fc / CD <= DB) dec[fc / CD - 1] = txd;
          fc++;
          if (fc == FRAME) begin
            check("frame_bits", berr, 0);
            check("frame_data", dec, ew);
            in_frame = 1'b0;
            post = 1'b1;
          end
        end
      end
      prev = resetn ? txd : 1'b1;
    end
  end

  task automatic send(input logic [DB-1:0] b, input int gap);
    int n;
    n = 0;
    if (gap > 0) begin
      ivalid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
    ivalid = 1'b1;
    idata = b;
    forever begin
      @(negedge clock);
      if (iready) begin
        sb.push_back(b);
        last_acc = cyc;
        break;
      end
      n++;
      if (n > 500) begin
        check("accept_timeout", iready, 1);
        break;
      end
    end
    @(posedge clock);
    #1;
    ivalid = 1'b0;
    idata = DB'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || in_frame || post) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) check("drain_timeout", n, 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
    $fatal(1);
  end

  initial begin : stim
    int            e_txd, e_rdy, e_busy, f0, gap;
    logic [DB-1:0] rb;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_txd", txd, 1);
    check("rst_iready", iready, 1);
    check("rst_busy", busy, 0);
    @(posedge clock);
    #1 resetn = 1'b1;

    e_txd = 0; e_rdy = 0; e_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (txd !== 1'b1) e_txd++;
      if (iready !== 1'b1) e_rdy++;
      if (busy !== 1'b0) e_busy++;
    end
    check("idle_txd_errs", e_txd, 0);
    check("idle_iready_errs", e_rdy, 0);
    check("idle_busy_errs", e_busy, 0);

    send(8'hA5, 1);
    @(negedge clock);
    check("a5_iready_drop", iready, 0);
    check("a5_busy_rise", busy, 1);
    drain();
    check("a5_fall_latency", fall_times[fall_times.size() - 1] - last_acc, 1);

    send(8'h00, 3);
    send(8'hFF, 0);
    drain();
    check("b2b_spacing", fall_times[fall_times.size() - 1] - fall_times[fall_times.size() - 2],
          FRAME + 1);

    send(8'h07, 2);
    drain();

    f0 = fall_times.size();
    for (int i = 0; i < 16; i++) begin
      rb = DB'($urandom);
      gap = int'($urandom_range(60, 0));
      send(rb, gap);
    end
    drain();
    check("rand_frame_count", fall_times.size() - f0, 16);

    send(8'h3C, 2);
    repeat (12) @(posedge clock);
    #1;
    check("pre_reset_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check("async_rst_txd", txd, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_iready", iready, 1);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    check("post_rst_iready", iready, 1);
    check("post_rst_txd", txd, 1);
    send(8'h81, 2);
    drain();

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
